// File: rtl/ramp_adc_ctrl.sv
// Ramp-compare ADC sequencer.
// Settles the DAC at code 0, then ramps the code upward one step at a time
// until the synchronized comparator reports a crossing. The crossing code is
// recovered from a short history of driven codes so that synchronizer latency
// does not bias the result. Supports one-shot and free-running operation.
module ramp_adc_ctrl #(
  parameter int CODE_W        = 8,
  parameter int STEP_CYCLES   = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int SYNC_LATENCY  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic              vcompare_sync,
  input  logic              cross_pulse,
  output logic [CODE_W-1:0] dac_code,
  output logic              busy,
  output logic [CODE_W-1:0] result,
  output logic              result_valid,
  output logic              overrange,
  output logic              underrange
);

  // A zero-latency configuration still gets a one-entry array so the
  // declaration stays legal; it is simply never read in that case.
  localparam int HIST_D   = (SYNC_LATENCY > 0) ? SYNC_LATENCY : 1;
  localparam int STEP_W   = $clog2(STEP_CYCLES + 1);
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [CODE_W-1:0]   CODE_FULL   = '1;
  localparam logic [STEP_W-1:0]   STEP_LAST   = STEP_W'(STEP_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_RAMP,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [STEP_W-1:0]   step_q;
  logic [SETTLE_W-1:0] settle_q;
  logic [CODE_W-1:0]   dac_q;
  logic [CODE_W-1:0]   result_q;
  logic                busy_q;
  logic                valid_q;
  logic                over_q;
  logic                under_q;
  logic [CODE_W-1:0]   hist_q [HIST_D];
  logic [CODE_W-1:0]   cap_code_d;

  // Code that was on the DAC when the comparator actually tripped.
  always_comb begin
    cap_code_d = dac_q;
    if (SYNC_LATENCY > 0) cap_code_d = hist_q[HIST_D-1];
  end

  // Conversion sequencer: state, counters, code history and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      step_q   <= '0;
      settle_q <= '0;
      dac_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      over_q   <= 1'b0;
      under_q  <= 1'b0;
      for (int i = 0; i < HIST_D; i++) hist_q[i] <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          dac_q  <= '0;
          busy_q <= 1'b0;
          if (start || continuous) begin
            state_q  <= S_SETTLE;
            busy_q   <= 1'b1;
            settle_q <= '0;
          end
        end

        S_SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            if (vcompare_sync) begin
              // Input is below the bottom of the ramp: report underrange.
              result_q <= '0;
              under_q  <= 1'b1;
              over_q   <= 1'b0;
              busy_q   <= 1'b0;
              valid_q  <= 1'b1;
              dac_q    <= '0;
              state_q  <= S_DONE;
            end else begin
              state_q <= S_RAMP;
              dac_q   <= '0;
              step_q  <= '0;
              // Codes from before this ramp must not leak into the result.
              for (int i = 0; i < HIST_D; i++) hist_q[i] <= '0;
            end
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end

        S_RAMP: begin
          hist_q[0] <= dac_q;
          for (int i = 1; i < HIST_D; i++) hist_q[i] <= hist_q[i-1];
          if (cross_pulse) begin
            // A crossing beats a simultaneous full-scale expiry.
            result_q <= cap_code_d;
            over_q   <= 1'b0;
            under_q  <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b1;
            dac_q    <= '0;
            state_q  <= S_DONE;
          end else if (step_q == STEP_LAST) begin
            step_q <= '0;
            if (dac_q == CODE_FULL) begin
              result_q <= CODE_FULL;
              over_q   <= 1'b1;
              under_q  <= 1'b0;
              busy_q   <= 1'b0;
              valid_q  <= 1'b1;
              dac_q    <= '0;
              state_q  <= S_DONE;
            end else begin
              dac_q <= dac_q + 1'b1;
            end
          end else begin
            step_q <= step_q + 1'b1;
          end
        end

        S_DONE: begin
          dac_q  <= '0;
          busy_q <= 1'b0;
          if (continuous) begin
            state_q  <= S_SETTLE;
            busy_q   <= 1'b1;
            settle_q <= '0;
          end else begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          dac_q   <= '0;
        end
      endcase
    end
  end

  assign dac_code     = dac_q;
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign overrange    = over_q;
  assign underrange   = under_q;

endmodule

// File: tb/tb_ramp_adc_ctrl.sv
// Bench for ramp_adc_ctrl: an analog comparator plus two-flop synchronizer
// around the default-parameter instance, and a zero-latency single-step
// instance whose cross_pulse is driven directly.
module tb_ramp_adc_ctrl;

  localparam int CODE_W = 8;
  localparam int STEP   = 4;
  localparam int SETTLE = 16;
  localparam int LAT    = 2;
  localparam int FULL   = (1 << CODE_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic continuous = 1'b0;
  logic vcompare_sync;
  logic cross_pulse;
  logic [CODE_W-1:0] dac_code;
  logic [CODE_W-1:0] result;
  logic busy, result_valid, overrange, underrange;

  logic start_b = 1'b0;
  logic cross_b = 1'b0;
  logic [CODE_W-1:0] dac_b;
  logic [CODE_W-1:0] res_b;
  logic busy_b, val_b, ovr_b, und_b;

  int vin = 1000;
  logic s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Comparator (ramp >= input) followed by a two-flop synchronizer and edge detect.
  always @(posedge clk) begin
    s1 <= (int'(dac_code) >= vin);
    s2 <= s1;
    s3 <= s2;
  end
  assign vcompare_sync = s2;
  assign cross_pulse   = s2 & ~s3;

  ramp_adc_ctrl #(
    .CODE_W(CODE_W), .STEP_CYCLES(STEP), .SETTLE_CYCLES(SETTLE), .SYNC_LATENCY(LAT)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous),
    .vcompare_sync(vcompare_sync), .cross_pulse(cross_pulse),
    .dac_code(dac_code), .busy(busy), .result(result), .result_valid(result_valid),
    .overrange(overrange), .underrange(underrange)
  );

  ramp_adc_ctrl #(
    .CODE_W(CODE_W), .STEP_CYCLES(1), .SETTLE_CYCLES(SETTLE), .SYNC_LATENCY(0)
  ) u_dut0 (
    .clk(clk), .reset(reset), .start(start_b), .continuous(1'b0),
    .vcompare_sync(1'b0), .cross_pulse(cross_b),
    .dac_code(dac_b), .busy(busy_b), .result(res_b), .result_valid(val_b),
    .overrange(ovr_b), .underrange(und_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Ideal converter: the first ramp code at or above VIN is VIN itself; the
  // busy time is settle + ramp up to that code + comparator latency + the
  // capture edge. Out-of-range inputs clamp to the ends of the code range.
  function automatic void model(input int v, output int r, output int ov,
                                output int un, output int bc);
    if (v == 0) begin
      r = 0; ov = 0; un = 1; bc = SETTLE;
    end else if (v > FULL) begin
      r = FULL; ov = 1; un = 0; bc = SETTLE + (FULL + 1) * STEP;
    end else begin
      r = v; ov = 0; un = 0; bc = SETTLE + v * STEP + LAT + 1;
    end
  endfunction

  task automatic wait_strobe(output bit got);
    got = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (result_valid) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_code(input int code, output bit got);
    got = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (int'(dac_code) == code) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_idle(input string tag, input int cycles);
    int strobes;
    int busy_cnt;
    strobes = 0;
    busy_cnt = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (result_valid) strobes++;
      if (busy) busy_cnt++;
    end
    chk({tag, " idle strobes"}, strobes, 0);
    chk({tag, " idle busy"}, busy_cnt, 0);
  endtask

  // One-shot conversion with a stray start pulse issued while busy.
  task automatic run_one(input int v, input string tag);
    int er, eo, eu, eb, bc;
    bit got, ramp_seen;
    model(v, er, eo, eu, eb);
    vin = v;
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    bc = 0;
    ramp_seen = 1'b0;
    for (int c = 0; c < 4000 && !got; c++) begin
      if (result_valid) begin
        got = 1'b1;
      end else begin
        if (busy) bc++;
        if (dac_code != '0) ramp_seen = 1'b1;
        start = (c == 20);
        @(negedge clk);
      end
    end
    start = 1'b0;
    chk({tag, " strobe"}, got, 1);
    chk({tag, " result"}, result, er);
    chk({tag, " overrange"}, overrange, eo);
    chk({tag, " underrange"}, underrange, eu);
    chk({tag, " busy at strobe"}, busy, 0);
    chk({tag, " dac at strobe"}, dac_code, 0);
    chk({tag, " busy cycles"}, bc, eb);
    if (v == 0) chk({tag, " no ramp"}, ramp_seen, 0);
    check_idle(tag, 30);
    chk({tag, " result held"}, result, er);
  endtask

  initial begin
    bit got;
    int bc;
    int rv;

    repeat (3) @(negedge clk);
    chk("reset dac", dac_code, 0);
    chk("reset busy", busy, 0);
    chk("reset result", result, 0);
    chk("reset valid", result_valid, 0);
    chk("reset over", overrange, 0);
    chk("reset under", underrange, 0);
    reset = 1'b0;

    run_one(100, "vin100");
    run_one(0, "vin0");
    run_one(300, "vin300");
    run_one(1, "vin1");
    run_one(255, "vin255");
    for (int k = 0; k < 6; k++) begin
      rv = int'($urandom_range(0, 300));
      run_one(rv, $sformatf("rand%0d_vin%0d", k, rv));
    end

    // Free-running: back-to-back conversions, then drop continuous mid-ramp.
    vin = 50;
    repeat (5) @(negedge clk);
    continuous = 1'b1;
    wait_strobe(got);
    chk("cont1 strobe", got, 1);
    chk("cont1 result", result, 50);
    vin = 200;
    @(negedge clk);
    chk("cont restart busy", busy, 1);
    wait_strobe(got);
    chk("cont2 strobe", got, 1);
    chk("cont2 result", result, 200);
    wait_code(100, got);
    chk("cont3 reached 100", got, 1);
    continuous = 1'b0;
    wait_strobe(got);
    chk("cont3 strobe", got, 1);
    chk("cont3 result", result, 200);
    check_idle("cont stop", 30);

    // Reset in the middle of a ramp aborts with no result.
    vin = 300;
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_code(37, got);
    chk("abort reached 37", got, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort dac", dac_code, 0);
    chk("abort busy", busy, 0);
    chk("abort result", result, 0);
    chk("abort over", overrange, 0);
    chk("abort under", underrange, 0);
    chk("abort valid", result_valid, 0);
    check_idle("abort", 40);

    // Zero-latency, single-step instance: full-scale overrange first.
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    got = 1'b0;
    bc = 0;
    for (int c = 0; c < 1000 && !got; c++) begin
      if (val_b) got = 1'b1;
      else begin
        if (busy_b) bc++;
        @(negedge clk);
      end
    end
    chk("b ovr strobe", got, 1);
    chk("b ovr result", res_b, FULL);
    chk("b ovr flag", ovr_b, 1);
    chk("b ovr busy cycles", bc, SETTLE + FULL + 1);

    // Direct crossing at code 10 and in the last full-scale cycle.
    for (int t = 0; t < 2; t++) begin
      int target;
      target = (t == 0) ? 10 : FULL;
      repeat (3) @(negedge clk);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 1000; c++) begin
        if (int'(dac_b) == target) begin
          got = 1'b1;
          break;
        end
        @(negedge clk);
      end
      chk($sformatf("b reach %0d", target), got, 1);
      cross_b = 1'b1;
      @(negedge clk);
      cross_b = 1'b0;
      chk($sformatf("b x%0d valid", target), val_b, 1);
      chk($sformatf("b x%0d result", target), res_b, target);
      chk($sformatf("b x%0d over", target), ovr_b, 0);
      chk($sformatf("b x%0d under", target), und_b, 0);
      chk($sformatf("b x%0d busy", target), busy_b, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
